// File: rtl/sprite_ram_writer_pkg.sv
// rtl/sprite_ram_writer_pkg.sv - shared VGA sprite geometry and writer FSM encoding
package sprite_ram_writer_pkg;

  localparam int SPRITE_W  = 32;
  localparam int SPRITE_H  = 35;
  localparam int ROW_W     = 6;
  localparam int COL_W     = 5;
  localparam int COLOR_W   = 12;
  localparam int SWAP_LINE = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PENDING = 2'd2
  } state_t;

endpackage

// File: rtl/sprite_ram_writer_if.sv
// rtl/sprite_ram_writer_if.sv - pixel stream handshake between sprite source and sprite RAM
interface sprite_ram_writer_if
  import sprite_ram_writer_pkg::*;
#(
  parameter int DATA_W = COLOR_W
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/sprite_ram_writer_dpram.sv
// rtl/sprite_ram_writer_dpram.sv - simple dual-port RAM, one write port, one registered read port
module sprite_ram_writer_dpram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 12
) (
  input  logic          ClkPort,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write and read share the clock; contents are intentionally never reset.
  always_ff @(posedge ClkPort) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sprite_ram_writer.sv
// rtl/sprite_ram_writer.sv - double-buffered sprite RAM swapped at vertical blanking
module sprite_ram_writer #(
  parameter int W         = sprite_ram_writer_pkg::SPRITE_W,
  parameter int H         = sprite_ram_writer_pkg::SPRITE_H,
  parameter int ROW_W     = sprite_ram_writer_pkg::ROW_W,
  parameter int COL_W     = sprite_ram_writer_pkg::COL_W,
  parameter int COLOR_W   = sprite_ram_writer_pkg::COLOR_W,
  parameter int SWAP_LINE = sprite_ram_writer_pkg::SWAP_LINE
) (
  input  logic               ClkPort,
  input  logic               rst,
  sprite_ram_writer_if.slave s,
  input  logic [9:0]         vCount,
  input  logic [ROW_W-1:0]   row,
  input  logic [COL_W-1:0]   col,
  output logic [COLOR_W-1:0] color_data,
  output logic               front_sel,
  output logic               busy,
  output logic               swap_done,
  output logic               frame_err
);

  import sprite_ram_writer_pkg::*;

  localparam int PW = ROW_W + COL_W;
  localparam int AW = 1 + PW;

  state_t             state;
  logic [ROW_W-1:0]   wr_row;
  logic [COL_W-1:0]   wr_col;
  logic               ready_q;
  logic               vblank_q;
  logic               row_ok_q;
  logic [COLOR_W-1:0] rd_data;

  // W is a power of two, so {row,col} is the row-major pixel index directly.
  logic [PW-1:0] pix_idx;
  logic          is_final;
  logic          accept;
  logic          vblank_now;
  logic          vblank_rise;

  assign pix_idx     = {wr_row, wr_col};
  assign is_final    = (pix_idx == PW'(W*H-1));
  assign accept      = s.s_valid && ready_q;
  assign s.s_ready   = ready_q;
  assign vblank_now  = (vCount >= 10'(SWAP_LINE));
  assign vblank_rise = vblank_now && !vblank_q;

  // Loader FSM: accepts a sprite into the back bank and swaps banks on the next vblank edge.
  always_ff @(posedge ClkPort) begin
    if (rst) begin
      state     <= IDLE;
      wr_row    <= '0;
      wr_col    <= '0;
      front_sel <= 1'b0;
      ready_q   <= 1'b1;
      busy      <= 1'b0;
      swap_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            if (is_final && s.s_last) begin
              state   <= PENDING;
              ready_q <= 1'b0;
              busy    <= 1'b1;
            end else if (is_final || s.s_last) begin
              // Length mismatch: drop the sprite, the back bank is simply overwritten later.
              state     <= IDLE;
              frame_err <= 1'b1;
              busy      <= 1'b0;
              wr_row    <= '0;
              wr_col    <= '0;
            end else begin
              state <= LOAD;
              busy  <= 1'b1;
              if (wr_col == COL_W'(W-1)) begin
                wr_col <= '0;
                wr_row <= wr_row + 1'b1;
              end else begin
                wr_col <= wr_col + 1'b1;
              end
            end
          end
        end
        PENDING: begin
          if (vblank_rise) begin
            state     <= IDLE;
            front_sel <= ~front_sel;
            ready_q   <= 1'b1;
            busy      <= 1'b0;
            swap_done <= 1'b1;
            wr_row    <= '0;
            wr_col    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Edge detector for entry into vertical blanking.
  always_ff @(posedge ClkPort) begin
    if (rst) vblank_q <= 1'b0;
    else     vblank_q <= vblank_now;
  end

  // Rows beyond the sprite height read as transparent zero, aligned with the RAM read latency.
  always_ff @(posedge ClkPort) begin
    if (rst) row_ok_q <= 1'b0;
    else     row_ok_q <= (row < ROW_W'(H));
  end

  assign color_data = row_ok_q ? rd_data : '0;

  sprite_ram_writer_dpram #(
    .DEPTH (2**AW),
    .AW    (AW),
    .DW    (COLOR_W)
  ) u_ram (
    .ClkPort (ClkPort),
    .wr_en   (accept),
    .wr_addr ({~front_sel, wr_row, wr_col}),
    .wr_data (s.s_data),
    .rd_addr ({front_sel, row, col}),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sprite_ram_writer.sv
// tb/tb_sprite_ram_writer.sv - self-checking bench for sprite_ram_writer
module tb_sprite_ram_writer;

  localparam int W    = 32;
  localparam int H    = 35;
  localparam int NPIX = W * H;

  logic        ClkPort = 1'b0;
  logic        rst;
  logic [9:0]  vCount;
  logic [5:0]  row;
  logic [4:0]  col;
  logic [11:0] color_data;
  logic        front_sel, busy, swap_done, frame_err;

  int total = 0;
  int bad   = 0;

  always #5 ClkPort = ~ClkPort;

  sprite_ram_writer_if #(.DATA_W(12)) sif ();

  sprite_ram_writer dut (
    .ClkPort    (ClkPort),
    .rst        (rst),
    .s          (sif),
    .vCount     (vCount),
    .row        (row),
    .col        (col),
    .color_data (color_data),
    .front_sel  (front_sel),
    .busy       (busy),
    .swap_done  (swap_done),
    .frame_err  (frame_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two banks as plain arrays, a pixel count and a pending flag.
  bit [11:0] m_mem   [2][NPIX];
  bit        m_known [2][NPIX];
  int        m_front, m_cnt, idx;
  bit        m_pend, m_vbq, m_valid, vb, rise;
  bit [11:0] e_color;
  bit        e_color_known, e_swap, e_ferr;
  int        n_swaps = 0;
  int        n_ferrs = 0;

  always @(posedge ClkPort) begin
    if (rst) begin
      m_front = 0; m_cnt = 0; m_pend = 0; m_vbq = 0;
      e_color = 0; e_color_known = 1; e_swap = 0; e_ferr = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (row < H) begin
        idx = row * W + col;
        e_color = m_mem[m_front][idx];
        e_color_known = m_known[m_front][idx];
      end else begin
        e_color = 0;
        e_color_known = 1;
      end
      e_swap = 0;
      e_ferr = 0;
      vb   = (vCount >= 480);
      rise = vb && !m_vbq;
      m_vbq = vb;
      if (m_pend) begin
        if (rise) begin
          m_front = 1 - m_front;
          m_pend  = 0;
          m_cnt   = 0;
          e_swap  = 1;
        end
      end else if (sif.s_valid) begin
        m_mem[1-m_front][m_cnt]   = sif.s_data;
        m_known[1-m_front][m_cnt] = 1;
        if (m_cnt == NPIX-1 && sif.s_last) m_pend = 1;
        else if (m_cnt == NPIX-1 || sif.s_last) begin
          e_ferr = 1;
          m_cnt  = 0;
        end else m_cnt++;
      end
    end
  end

  // Compare all outputs against the model every cycle once reset has been seen.
  always @(negedge ClkPort) begin
    if (m_valid) begin
      check("s_ready",   32'(sif.s_ready), 32'(!m_pend));
      check("busy",      32'(busy),        32'(m_pend || m_cnt != 0));
      check("front_sel", 32'(front_sel),   32'(m_front));
      check("swap_done", 32'(swap_done),   32'(e_swap));
      check("frame_err", 32'(frame_err),   32'(e_ferr));
      if (e_color_known) check("color_data", 32'(color_data), 32'(e_color));
      if (swap_done === 1'b1) n_swaps++;
      if (frame_err === 1'b1) n_ferrs++;
    end
  end

  bit rand_rd = 1'b0;

  // Random read addresses whenever the main sequence is not pinning one.
  initial begin
    forever begin
      @(posedge ClkPort); #1;
      if (rand_rd) begin
        row = 6'($urandom_range(0, 63));
        col = 5'($urandom);
      end
    end
  end

  task automatic tick();
    @(posedge ClkPort); #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (sif.s_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (sif.s_ready !== 1'b1) check("ready_timeout", 32'(sif.s_ready), 32'd1);
  endtask

  task automatic send(input int count, input int last_idx, input int mode, input int base);
    for (int i = 0; i < count; i++) begin
      if (mode == 1) begin
        sif.s_valid = 1'b0;
        tick();
      end else if (mode == 2) begin
        repeat ($urandom_range(0, 2)) begin
          sif.s_valid = 1'b0;
          tick();
        end
      end
      wait_ready();
      sif.s_data  = 12'(base + i);
      sif.s_last  = (i == last_idx);
      sif.s_valid = 1'b1;
      tick();
    end
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
  endtask

  task automatic vblank(input logic exp_front);
    vCount = 10'd479;
    tick();
    vCount = 10'd480;
    tick();
    check("swap_front", 32'(front_sel), 32'(exp_front));
    check("swap_pulse", 32'(swap_done), 32'd1);
    check("swap_ready", 32'(sif.s_ready), 32'd1);
    tick();
    check("swap_pulse_end", 32'(swap_done), 32'd0);
    vCount = 10'd0;
    tick();
  endtask

  task automatic read_lit(input int r, input int c, input int exp);
    rand_rd = 1'b0;
    row = 6'(r);
    col = 5'(c);
    tick();
    check("read_lit", 32'(color_data), 32'(exp));
    rand_rd = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.s_data  = '0;
    vCount = 10'd0;
    row = 6'd63;
    col = 5'd0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_front", 32'(front_sel), 32'd0);
    check("rst_color", 32'(color_data), 32'd0);
    check("rst_ready", 32'(sif.s_ready), 32'd1);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_pulses", 32'({swap_done, frame_err}), 32'd0);
    tick();
    check("post_rst_ready", 32'(sif.s_ready), 32'd1);
    check("post_rst_busy",  32'(busy), 32'd0);
    rand_rd = 1'b1;

    // Full load then swap.
    send(NPIX, NPIX-1, 0, 0);
    check("full_ready_low", 32'(sif.s_ready), 32'd0);
    check("full_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    check("pending_front", 32'(front_sel), 32'd0);
    vblank(1'b1);
    read_lit(3, 5, 101);
    read_lit(34, 31, 1119);
    read_lit(40, 0, 0);

    // Early s_last aborts without swapping.
    send(100, 99, 2, 0);
    check("early_ferr",  32'(frame_err), 32'd1);
    check("early_front", 32'(front_sel), 32'd1);
    check("early_ready", 32'(sif.s_ready), 32'd1);
    send(NPIX, NPIX-1, 2, 7);
    vblank(1'b0);
    read_lit(0, 0, 7);
    read_lit(3, 5, 108);

    // Valid toggling every cycle.
    send(NPIX, NPIX-1, 1, 0);
    vblank(1'b1);
    read_lit(3, 5, 101);

    // Completion coincident with vblank rise, then held in vblank.
    vCount = 10'd479;
    send(NPIX-1, -1, 0, 200);
    sif.s_data  = 12'(200 + NPIX - 1);
    sif.s_last  = 1'b1;
    sif.s_valid = 1'b1;
    vCount = 10'd480;
    tick();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    check("vb_busy", 32'(busy), 32'd1);
    vCount = 10'd500;
    repeat (3) tick();
    check("vb_hold_front", 32'(front_sel), 32'd1);
    vCount = 10'd524;
    tick();
    vCount = 10'd0;
    tick();
    check("vb_wrap_front", 32'(front_sel), 32'd1);
    vCount = 10'd480;
    tick();
    check("vb_swap_front", 32'(front_sel), 32'd0);
    check("vb_swap_pulse", 32'(swap_done), 32'd1);
    vCount = 10'd0;
    tick();
    read_lit(3, 5, 301);

    // Reset mid-load, then full reload.
    send(500, -1, 2, 0);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("mid_rst_front", 32'(front_sel), 32'd0);
    check("mid_rst_busy",  32'(busy), 32'd0);
    check("mid_rst_ready", 32'(sif.s_ready), 32'd1);
    check("mid_rst_ferr",  32'(frame_err), 32'd0);
    send(NPIX, NPIX-1, 0, 50);
    vblank(1'b1);
    read_lit(40, 3, 0);
    read_lit(3, 5, 151);

    repeat (2) tick();
    check("swap_count", 32'(n_swaps), 32'd5);
    check("ferr_count", 32'(n_ferrs), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_ram_writer.md
# sprite_ram_writer

Double-buffered sprite RAM for the VGA sprite controllers. A streaming source loads a 32x35 sprite of 12-bit colors in row-major order into the back bank. At the next vertical-blanking edge the back bank is swapped to the front. A sprite controller reads the front bank through a row/col port with the same 1-cycle latency and addressing as the fixed sprite ROMs, so a ROM-based sprite can be replaced at run time without tearing.

## Interface
Parameters:
- W, 32: sprite width in pixels; must be a power of two.
- H, 35: sprite height in pixels.
- ROW_W, 6: row address width.
- COL_W, 5: column address width; equals log2(W).
- COLOR_W, 12: color width, 4:4:4 RGB.
- SWAP_LINE, 480: first vCount value of vertical blanking.

Ports:
- ClkPort, in, 1: the single clock for all logic, including the RAM.
- rst, in, 1: synchronous, active-high reset.
- s_data, in, COLOR_W: incoming pixel color.
- s_valid, in, 1: s_data is valid.
- s_last, in, 1: marks the final pixel of a sprite.
- s_ready, out, 1: the block accepts a pixel.
- vCount, in, 10: current VGA line.
- row, in, ROW_W: read row.
- col, in, COL_W: read column.
- color_data, out, COLOR_W: registered read data from the front bank.
- front_sel, out, 1: index of the bank currently displayed.
- busy, out, 1: high in LOAD or PENDING.
- swap_done, out, 1: one-cycle pulse after a swap.
- frame_err, out, 1: one-cycle pulse when a sprite is discarded.

## Operation
- Storage:
  - 2 x 2^(ROW_W+COL_W) x COLOR_W, addressed {bank, row, col}.
  - Writes go to bank ~front_sel; reads come from bank front_sel.
  - RAM contents are not reset.
- A pixel is accepted on any cycle with s_valid && s_ready.
- Write pointers wr_col and wr_row:
  - wr_col increments on each accepted pixel.
  - When wr_col reaches W-1 it wraps to 0 and wr_row increments.
  - Pixel index n = wr_row*W + wr_col; the last index is W*H-1 = 1119.
- FSM:
  - IDLE:
    - s_ready=1.
    - An accepted pixel is written and the FSM moves to LOAD.
    - If W*H==1 and s_last is set, go directly to PENDING (degenerate case).
  - LOAD:
    - s_ready=1.
    - If the accepted pixel has n==W*H-1 and s_last=1, go to PENDING.
    - If (n==W*H-1 and s_last=0) or (n<W*H-1 and s_last=1): pulse frame_err, clear the pointers, go to IDLE. No swap occurs; the partially written back bank is ignored.
  - PENDING:
    - s_ready=0.
    - On vblank_rise: toggle front_sel, clear the pointers, go to IDLE.
- vblank detection:
  - vblank_q <= (vCount >= SWAP_LINE).
  - vblank_rise = (vCount >= SWAP_LINE) && !vblank_q.
  - A swap happens only from PENDING, so load completion and vblank_rise in the same cycle do not swap; the swap waits for the next rise.
- Read path:
  - color_data <= (row < H) ? ram[{front_sel,row,col}] : 0.
  - Uses front_sel as registered at the read edge.
  - col needs no range check because W = 2^COL_W.
- Reset values:
  - state=IDLE, pointers 0, front_sel=0, color_data=0, vblank_q=0.
  - swap_done=0, frame_err=0.
  - s_ready=1 and busy=0 from the first cycle after reset.
  - Reset mid-load or in PENDING discards the sprite with no frame_err.

## Timing
- Throughput: one pixel per cycle; s_valid may gap arbitrarily.
- s_ready is a pure function of state, with no combinational path from s_valid.
- Write: the accepted pixel is in RAM at the edge where it is accepted. A read of the same address in a later cycle sees it, but only after the swap makes the bank front.
- Last-pixel acceptance at edge k: s_ready=0 and busy=1 from cycle k+1.
- Swap timing:
  - front_sel toggles at the edge where vblank_rise=1.
  - swap_done=1 for exactly the next cycle.
  - s_ready=1 in that same next cycle.
- Read latency: 1 cycle from row/col to color_data, identical to the sprite ROMs. The consumer delays its sprite-window enable by one cycle.

## Structure
- Shared VGA package, reused by the sprite controllers:
  - SPRITE_W, SPRITE_H, ROW_W, COL_W, COLOR_W, SWAP_LINE.
  - FSM state encoding: IDLE, LOAD, PENDING.
- Sub-module sprite_dpram:
  - Simple dual-port RAM on ClkPort: one write port, one registered read port.
  - Parameterised by depth and width; inferable as block RAM.

## Test plan
1. Reset:
   - Stimulus: assert rst for 2 cycles, then release.
   - Required response: front_sel=0, color_data=0, s_ready=1, busy=0, no pulses.
2. Full load and swap:
   - Stimulus: stream 1120 pixels with data = n[11:0] and s_last on n=1119. Then step vCount 479->480.
   - Required response: s_ready=0 after the last pixel. front_sel=1, swap_done pulses once. Reading row=3, col=5 gives 12'd101 one cycle later.
3. Early s_last:
   - Stimulus: s_last on n=99.
   - Required response: frame_err pulses, front_sel is unchanged, s_ready stays 1, and the next pixel is written at row 0, col 0.
4. Backpressure and gaps:
   - Stimulus: s_valid toggles every cycle during the load.
   - Required response: same RAM contents and swap result as scenario 2.
5. Completion during vblank:
   - Stimulus: finish the load with vCount=500.
   - Required response: no swap until vCount goes 524->0->480, then front_sel toggles.
6. Reset mid-load:
   - Stimulus: assert rst at pixel 500, then do a full reload.
   - Required response: the reload swaps into bank 1. Reading row=40 returns 0.
